// File: rtl/piso_shifter_tx.sv
// rtl/piso_shifter_tx.sv - parallel-in serial-out transmitter, MSB first, gapless back-to-back words
// Optional feature macro: PISO_SHIFTER_PARITY_EN (appends one even-parity bit after the LSB)
module piso_shifter_tx #(
   parameter int   WIDTH      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             dout,
   output logic             busy,
   output logic             last
);

`ifdef PISO_SHIFTER_PARITY_EN
   // Parity rides in the shift register as one extra LSB so it falls out after the data bits.
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int            CW       = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [NBITS-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [NBITS-1:0] word;
   logic             accept;

`ifdef PISO_SHIFTER_PARITY_EN
   assign word = {load_data, ^load_data};
`else
   assign word = load_data;
`endif

   // State, shift register and bit counter; clr aborts any word in flight immediately.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Handshake, framing outputs and next-state; reload on the final bit keeps words gapless.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      cnt_nxt    = cnt;
      busy       = (state == SHIFT);
      last       = (state == SHIFT) && (cnt == LAST_CNT);
      load_ready = clr && ((state == IDLE) || last);
      accept     = load_valid && load_ready;
      dout       = busy ? shreg[NBITS-1] : IDLE_LEVEL;
      case (state)
         IDLE: begin
            if (accept) begin
               shreg_nxt = word;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               if (accept) begin
                  shreg_nxt = word;
                  cnt_nxt   = '0;
               end else begin
                  shreg_nxt = '0;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end else begin
               shreg_nxt = {shreg[NBITS-2:0], 1'b0};
               cnt_nxt   = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_piso_shifter_tx.sv
// tb/tb_piso_shifter_tx.sv - scoreboard testbench for piso_shifter_tx
module tb_piso_shifter_tx;

   localparam int   WIDTH    = 4;
   localparam logic IDLE_LVL = 1'b0;
`ifdef PISO_SHIFTER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NB = WIDTH + (PAR ? 1 : 0);

   logic             clk = 1'b0;
   logic             clr;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             dout;
   logic             busy;
   logic             last;
   logic [WIDTH-1:0] sipo;

   int total = 0;
   int bad   = 0;

   // expected {dout, busy, last} per cycle
   typedef logic [2:0] item_t;
   item_t sb[$];
   item_t e;

   piso_shifter_tx #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LVL)) dut (
      .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .dout(dout), .busy(busy), .last(last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) sipo <= {sipo[WIDTH-2:0], dout};

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--)
         sb.push_back({w[i], 1'b1, (i == 0) && !PAR});
      if (PAR) sb.push_back({^w, 1'b1, 1'b1});
   endtask

   task automatic push_idle();
      sb.push_back({IDLE_LVL, 1'b0, 1'b0});
   endtask

   task automatic test_reset();
      clr = 1'b0; load_valid = 1'b0; load_data = '0; sipo = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({dout, busy, last, load_ready} !== {IDLE_LVL, 3'b000}) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", {dout, busy, last, load_ready}, {IDLE_LVL, 3'b000});
      end
      clr = 1'b1;
   endtask

   task automatic test_single();
      load_valid = 1'b1; load_data = 4'b1011;
      #1;
      total++;
      if (load_ready !== 1'b1) begin
         bad++; $display("FAIL single_ready got=%b exp=1", load_ready);
      end
      push_word(4'b1011); push_idle();
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL single_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c == 1) load_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      load_valid = 1'b1; load_data = 4'b1011;
      push_word(4'b1011);
      for (int c = 1; c <= 2 * NB + 1; c++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            total++; bad++; $display("FAIL b2b_c%0d scoreboard empty got=%b exp=entry", c, {dout, busy, last});
         end else begin
            e = sb.pop_front(); total++;
            if ({dout, busy, last} !== e) begin
               bad++; $display("FAIL b2b_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
            end
         end
         if (c <= NB) begin
            total++;
            if (load_ready !== (c == NB)) begin
               bad++; $display("FAIL b2b_ready_c%0d got=%b exp=%b", c, load_ready, c == NB);
            end
         end
         if (c == 1) begin
            load_data = 4'b0110; push_word(4'b0110);
         end
         if (c == NB + 1) begin
            load_valid = 1'b0; push_idle();
         end
      end
   endtask

   task automatic test_loopback();
      load_valid = 1'b1; load_data = 4'b1100;
      push_word(4'b1100); push_idle();
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL loop_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c == WIDTH + 1) begin
            total++;
            if (sipo !== 4'b1100) begin
               bad++; $display("FAIL loop_sipo got=%b exp=1100", sipo);
            end
         end
         if (c == 1) load_valid = 1'b0;
      end
   endtask

   task automatic test_ignore();
      load_valid = 1'b1; load_data = 4'b0001;
      push_word(4'b0001); push_idle();
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL ignore_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c <= 3) begin
            total++;
            if (load_ready !== 1'b0) begin
               bad++; $display("FAIL ignore_ready_c%0d got=%b exp=0", c, load_ready);
            end
         end
         if (c == 1) load_valid = 1'b0;
         if (c == 2) begin
            load_valid = 1'b1; load_data = 4'b1111;
         end
         if (c == 3) load_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      load_valid = 1'b1; load_data = 4'b1010;
      push_word(4'b1010);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL rstmid_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c == 1) load_valid = 1'b0;
      end
      #1 clr = 1'b0;
      #1;
      total++;
      if ({dout, busy, last, load_ready} !== {IDLE_LVL, 3'b000}) begin
         bad++;
         $display("FAIL rstmid_abort got=%b exp=%b", {dout, busy, last, load_ready}, {IDLE_LVL, 3'b000});
      end
      sb.delete();
      @(negedge clk);
      clr = 1'b1; load_valid = 1'b1; load_data = 4'b0101;
      push_word(4'b0101); push_idle();
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL rstmid_next_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c == 1) load_valid = 1'b0;
      end
   endtask

   task automatic test_parity_word();
      load_valid = 1'b1; load_data = 4'b0111;
      push_word(4'b0111); push_idle();
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         e = sb.pop_front(); total++;
         if ({dout, busy, last} !== e) begin
            bad++; $display("FAIL parity_c%0d got=%b exp=%b", c, {dout, busy, last}, e);
         end
         if (c == 1) load_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_loopback();
      test_ignore();
      test_reset_mid();
      test_parity_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
